// File: rtl/wide_compare_seq.sv
// wide_compare_seq: byte-serial unsigned magnitude comparator.
// Compares two 8*NBYTES-bit operands by running one 8-bit comparator over
// one byte per clock, LSB first. The registered lt/eq/gt of each byte is the
// cascade input of the next byte, so the most significant differing byte
// decides the result.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous reset, active-high (has priority over start)
//   start  - request a comparison; accepted when busy=0 (IDLE or FIN)
//   a_in   - operand A, sampled on the accepting edge only
//   b_in   - operand B, sampled on the accepting edge only
//   busy   - comparison in progress (RUN state)
//   done   - one-cycle pulse, lt/eq/gt just updated
//   lt     - A < B  of the last completed comparison
//   eq     - A == B of the last completed comparison
//   gt     - A > B  of the last completed comparison
module wide_compare_seq #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a_in,
    input  logic [8*NBYTES-1:0]   b_in,
    output logic                  busy,
    output logic                  done,
    output logic                  lt,
    output logic                  eq,
    output logic                  gt
);

    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    // Cascade seed {l,e,g}: "equal so far" so an all-equal operand pair reports eq.
    localparam logic [2:0] CASC_INIT = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [NBYTES-1:0][7:0]   op_a_q, op_a_d;
    logic [NBYTES-1:0][7:0]   op_b_q, op_b_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [2:0]               casc_q, casc_d;
    logic [2:0]               res_q, res_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [7:0]               byte_a;
    logic [7:0]               byte_b;
    logic [2:0]               cmp_res;

    // Shared 8-bit comparator with cascade; outputs ordered {lt,eq,gt}.
    always_comb begin
        byte_a  = op_a_q[idx_q];
        byte_b  = op_b_q[idx_q];
        cmp_res = casc_q;
        if (byte_a > byte_b) begin
            cmp_res = 3'b001;
        end else if (byte_a < byte_b) begin
            cmp_res = 3'b100;
        end
    end

    // Next-state and register update logic.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        idx_d   = idx_q;
        casc_d  = casc_q;
        res_d   = res_q;

        case (state_q)
            S_IDLE, S_FIN: begin
                // FIN accepts start exactly like IDLE for back-to-back operation.
                if (start) begin
                    op_a_d  = a_in;
                    op_b_d  = b_in;
                    idx_d   = '0;
                    casc_d  = CASC_INIT;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                casc_d = cmp_res;
                if (idx_q == LAST_IDX) begin
                    res_d   = cmp_res;
                    state_d = S_FIN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_FIN);
    end

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            idx_q   <= '0;
            casc_q  <= CASC_INIT;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            idx_q   <= idx_d;
            casc_q  <= casc_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign lt   = res_q[2];
    assign eq   = res_q[1];
    assign gt   = res_q[0];

endmodule
